// File: rtl/companion_pkg.sv
// Shared action codes and sequencer state encoding for the companion menu blocks.
package companion_pkg;

    localparam int unsigned ACT_W   = 2;
    localparam int unsigned FRAME_W = 4;

    typedef enum logic [ACT_W-1:0] {
        ACT_NONE  = 2'd0,
        ACT_FEED  = 2'd1,
        ACT_PLAY  = 2'd2,
        ACT_CLEAN = 2'd3
    } action_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/companion_action_sequencer_frame_timer.sv
// Free-running frame-period timer; tick is high for one cycle every FRAME_TICKS cycles.
module frame_timer #(
    parameter int unsigned FRAME_TICKS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(FRAME_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next_c;

    // Next count wraps at the end of each frame period.
    always_comb begin
        cnt_next_c = (cnt == CNT_LAST) ? '0 : CNT_W'(cnt + 1'b1);
    end

    // Tick is registered alongside the count so it lines up with the last cycle of the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= (FRAME_TICKS == 1);
        end else if (clear) begin
            cnt  <= '0;
            tick <= (FRAME_TICKS == 1);
        end else begin
            cnt  <= cnt_next_c;
            tick <= (cnt_next_c == CNT_LAST);
        end
    end

endmodule

// File: rtl/companion_action_sequencer.sv
// Runs the frame-timed animation of the selected pet action and an idle loop otherwise.
module companion_action_sequencer #(
    parameter int unsigned CLOCK_FREQ   = 50_000_000,
    parameter int unsigned FRAME_RATE   = 10,
    parameter int unsigned FEED_FRAMES  = 8,
    parameter int unsigned PLAY_FRAMES  = 8,
    parameter int unsigned CLEAN_FRAMES = 12,
    parameter int unsigned IDLE_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exec,
    input  logic [1:0] selected,
    input  logic       abort,
    output logic       exec_status,
    output logic [1:0] sprite_id,
    output logic [3:0] frame_index,
    output logic       frame_strobe
);

    import companion_pkg::*;

    // Frame counts are expected to lie in 1..16 so the last index fits in 4 bits.
    localparam int unsigned RAW_TICKS   = CLOCK_FREQ / FRAME_RATE;
    localparam int unsigned FRAME_TICKS = (RAW_TICKS < 1) ? 1 : RAW_TICKS;

    localparam logic [FRAME_W-1:0] IDLE_LAST  = FRAME_W'(IDLE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FEED_LAST  = FRAME_W'(FEED_FRAMES - 1);
    localparam logic [FRAME_W-1:0] PLAY_LAST  = FRAME_W'(PLAY_FRAMES - 1);
    localparam logic [FRAME_W-1:0] CLEAN_LAST = FRAME_W'(CLEAN_FRAMES - 1);

    seq_state_e         state;
    action_e            action;
    logic               exec_q;
    logic               tick;
    logic               start_go_c;
    logic               abort_go_c;
    logic               timer_clear_c;
    logic [FRAME_W-1:0] run_last_c;

    // Start is a rising edge of exec with a real action while idle; abort only matters in RUN.
    always_comb begin
        start_go_c    = exec && !exec_q && (state == IDLE) && (selected != ACT_NONE);
        abort_go_c    = (state == RUN) && abort;
        timer_clear_c = start_go_c || abort_go_c;
    end

    // Last frame index of the latched action.
    always_comb begin
        run_last_c = FEED_LAST;
        case (action)
            ACT_PLAY:  run_last_c = PLAY_LAST;
            ACT_CLEAN: run_last_c = CLEAN_LAST;
            default:   run_last_c = FEED_LAST;
        endcase
    end

    frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_frame_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear_c),
        .tick (tick)
    );

    // Sequencer FSM with registered sprite/frame/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            action       <= ACT_NONE;
            exec_q       <= 1'b0;
            exec_status  <= 1'b1;
            sprite_id    <= 2'd0;
            frame_index  <= '0;
            frame_strobe <= 1'b0;
        end else begin
            exec_q       <= exec;
            frame_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_go_c) begin
                        state        <= RUN;
                        action       <= action_e'(selected);
                        sprite_id    <= selected;
                        exec_status  <= 1'b0;
                        frame_index  <= '0;
                        frame_strobe <= 1'b1;
                    end else if (tick) begin
                        frame_index  <= (frame_index == IDLE_LAST) ? '0 : FRAME_W'(frame_index + 1'b1);
                        frame_strobe <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_go_c || (tick && (frame_index == run_last_c))) begin
                        state        <= IDLE;
                        exec_status  <= 1'b1;
                        sprite_id    <= 2'd0;
                        frame_index  <= '0;
                        frame_strobe <= 1'b1;
                    end else if (tick) begin
                        frame_index  <= FRAME_W'(frame_index + 1'b1);
                        frame_strobe <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/companion_action_sequencer.md
# companion_action_sequencer

Sequences the timed execution of a pet action chosen in the companion menu. It accepts the `exec`/`selected` request from `companion_interface` and runs a frame-timed animation for the chosen action (feed, play, clean up). It drives the `exec_status` completion handshake back to the interface. It is the only owner of the sprite/frame outputs consumed by the display path, and plays an idle loop whenever no action is running.

## Interface
Parameters:
- `CLOCK_FREQ`, default 50_000_000: clock frequency in Hz.
- `FRAME_RATE`, default 10: animation frames per second.
- `FEED_FRAMES`, default 8: frame count of the feed action.
- `PLAY_FRAMES`, default 8: frame count of the play action.
- `CLEAN_FRAMES`, default 12: frame count of the clean-up action.
- `IDLE_FRAMES`, default 4: length of the idle loop.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `exec`  in  1  action request level from `companion_interface`; a rising edge starts an action.
- `selected`  in  2  action code, sampled on the `exec` rising edge: 1 feed, 2 play, 3 clean, 0 none.
- `abort`  in  1  cancels a running action; synchronous level.
- `exec_status`  out  1  1 = idle/done, 0 = action running.
- `sprite_id`  out  2  animation being shown: 0 idle, otherwise the action code.
- `frame_index`  out  4  current frame within the animation.
- `frame_strobe`  out  1  one-cycle pulse on every frame change.

## Operation
- `FRAME_TICKS = max(1, CLOCK_FREQ / FRAME_RATE)`, computed at elaboration.
- Tick counter width is `$clog2(FRAME_TICKS+1)`.
- All frame-count parameters must be in the range 1..16.
- State machine:
  - IDLE: loops `frame_index` 0..IDLE_FRAMES-1, wrapping to 0, advancing every FRAME_TICKS cycles. `sprite_id` = 0 and `exec_status` = 1.
  - RUN: plays the latched action from frame 0 to N-1, where N comes from the action code. Each frame is held FRAME_TICKS cycles. After the last frame's hold expires, go to IDLE.
- `exec` is registered (`exec_q`). A start occurs in a cycle where `exec` = 1 and `exec_q` = 0.
- On a start in IDLE with `selected` ≠ 0:
  - latch `selected`;
  - go to RUN;
  - `frame_index` ← 0;
  - tick counter ← 0;
  - `frame_strobe` pulses.
- Start with `selected` = 0: ignored; remain in IDLE with `exec_status` = 1.
- Start while in RUN: ignored. The latched action is not changed.
- `abort` high in RUN: next cycle go to IDLE, `frame_index` ← 0, `exec_status` = 1, `frame_strobe` pulses. `abort` in IDLE has no effect.
- Start and `abort` in the same IDLE cycle: the start wins, because `abort` is only evaluated in RUN.
- Returning to IDLE, by completion or abort, restarts the idle loop at frame 0.

## Timing
- Reset values: state IDLE, `exec_status` = 1, `sprite_id` = 0, `frame_index` = 0, `frame_strobe` = 0, `exec_q` = 0, tick counter 0.
- All outputs are registered.
- Let E be the cycle in which a valid start is sampled.
  - RUN is visible from E+1.
  - `exec_status` = 0 for exactly N × FRAME_TICKS cycles, from E+1 through E+N×FRAME_TICKS.
  - `exec_status` is 1 again at E+N×FRAME_TICKS+1.
- `frame_strobe` is high at:
  - E+1;
  - every later frame boundary;
  - the return-to-IDLE cycle.
  - It is never high two cycles in a row unless FRAME_TICKS = 1.
- FRAME_TICKS = 1: the frame advances every cycle and `frame_strobe` stays high while running.
- Asserting `rst` mid-action forces the reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `companion_pkg` holds:
  - action codes: ACT_NONE = 0, ACT_FEED = 1, ACT_PLAY = 2, ACT_CLEAN = 3;
  - the sequencer state enum (IDLE, RUN).
  - `companion_interface` uses the same action codes.
- Sub-module `frame_timer`:
  - parameter FRAME_TICKS;
  - inputs `clk`, `rst`, `clear`;
  - output `tick`, a one-cycle pulse every FRAME_TICKS cycles, restarting from 0 on `clear`.
- The frame counter, the action-length mux and the FSM live in the top module.

## Test plan
Common bench parameters: CLOCK_FREQ = 40, FRAME_RATE = 10 (FRAME_TICKS = 4); other parameters at defaults.
- Reset, then 40 idle cycles:
  - `exec_status` = 1 and `sprite_id` = 0 throughout;
  - `frame_index` steps 0, 1, 2, 3, 0, … every 4 cycles.
- `exec` rises with `selected` = 1 at cycle E:
  - `exec_status` = 0 during E+1..E+32 and 1 at E+33;
  - `sprite_id` = 1 during RUN;
  - `frame_index` reaches 7;
  - 9 strobes in total.
- `selected` = 3: `exec_status` low for 48 cycles and `frame_index` reaches 11.
- `selected` = 2, with `exec` toggled again at E+10 and `selected` changed to 3:
  - `sprite_id` stays 2;
  - completion still occurs at E+33.
- Feed started, `abort` = 1 at E+12:
  - `exec_status` = 1, `sprite_id` = 0 and `frame_index` = 0 at E+13;
  - `frame_strobe` pulses at E+13.
- `exec` rises with `selected` = 0: no state change and `exec_status` stays 1.
- `rst` asserted mid-RUN between clock edges: all outputs return to their reset values without a clock edge.
